sec_mark_gen: RTL and testbench

Generates the one-second mark consumed by the uptime seconds counter. Disciplines the mark to an external 1PPS input when that input is valid. Free-runs from the local clock when 1PPS is absent or invalid. Reports lock and holdover status and the last measured 1PPS period.

---
 rtl/sec_mark_gen.sv | 190 +++++++++++++++++++
 tb/tb_sec_mark_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sec_mark_gen.sv
// sec_mark_gen: one-second mark generator for the uptime seconds counter.
//
// The mark is disciplined to an external 1PPS input once that input has
// qualified. The mark free-runs from the local clock when 1PPS is absent
// or out of tolerance. Lock/holdover status and the last measured 1PPS
// period are reported.
//
// Parameters:
//   CLK_HZ   nominal clk cycles per second
//   TOL      accepted 1PPS period deviation, +/- clk cycles
//   QUAL     consecutive in-tolerance intervals needed to lock
//   LOST_CNT consecutive missed 1PPS edges before holdover
//   PULSE_W  width of the sec pulse in clk cycles
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   pps_in     external 1PPS, asynchronous, rising edge significant
//   sec        one-second mark, high for PULSE_W cycles
//   locked     mark is disciplined to pps_in
//   holdover   lock was lost, mark is free-running
//   pps_period clk cycles between the last two pps_in edges (saturating)
module sec_mark_gen #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned TOL      = 1000,
  parameter int unsigned QUAL     = 2,
  parameter int unsigned LOST_CNT = 3,
  parameter int unsigned PULSE_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pps_in,
  output logic        sec,
  output logic        locked,
  output logic        holdover,
  output logic [31:0] pps_period
);

  localparam int unsigned IvlW      = $clog2(CLK_HZ + TOL + 1);
  localparam int unsigned QualW     = $clog2(QUAL + 1);
  localparam int unsigned MissW     = $clog2(LOST_CNT + 1);
  localparam int unsigned PulseCntW = $clog2(PULSE_W + 1);

  localparam logic [IvlW-1:0]      IvlFree   = IvlW'(CLK_HZ - 1);
  localparam logic [IvlW-1:0]      IvlWinLo  = IvlW'(CLK_HZ - TOL - 1);
  localparam logic [IvlW-1:0]      IvlWinHi  = IvlW'(CLK_HZ + TOL - 1);
  localparam logic [IvlW-1:0]      IvlTol    = IvlW'(TOL);
  localparam logic [IvlW-1:0]      IvlSettle = IvlW'(2 * PULSE_W);
  localparam logic [31:0]          PerLo     = 32'(CLK_HZ - TOL);
  localparam logic [31:0]          PerHi     = 32'(CLK_HZ + TOL);
  localparam logic [QualW-1:0]     QualLast  = QualW'(QUAL - 1);
  localparam logic [MissW-1:0]     MissLast  = MissW'(LOST_CNT - 1);
  localparam logic [PulseCntW-1:0] PulseLoad = PulseCntW'(PULSE_W);

  typedef enum logic [1:0] {StSearch, StLocked, StHoldover} state_e;

  state_e                 state_q, state_d;
  logic                   s1_q, s2_q, s3_q;
  logic                   pps_edge;
  logic [31:0]            pps_cnt_q, pps_cnt_d;
  logic [31:0]            pps_period_q, pps_period_d;
  logic [31:0]            period_meas;
  logic                   interval_good;
  logic                   in_window;
  logic [IvlW-1:0]        ivl_q, ivl_d;
  logic [QualW-1:0]       qual_q, qual_d;
  logic [MissW-1:0]       miss_q, miss_d;
  logic [PulseCntW-1:0]   pulse_q, pulse_d;
  logic                   mark;

  // Two synchronizer flops plus one delay flop for edge detection.
  assign pps_edge = s2_q & ~s3_q;

  // Interval measured at this edge, saturating at all-ones.
  assign period_meas   = (pps_cnt_q == '1) ? '1 : pps_cnt_q + 32'd1;
  assign interval_good = (period_meas >= PerLo) && (period_meas <= PerHi);
  assign in_window     = (ivl_q >= IvlWinLo) && (ivl_q <= IvlWinHi);

  always_comb begin
    pps_cnt_d    = (pps_cnt_q == '1) ? pps_cnt_q : pps_cnt_q + 32'd1;
    pps_period_d = pps_period_q;
    if (pps_edge) begin
      pps_cnt_d    = '0;
      pps_period_d = period_meas;
    end
  end

  always_comb begin
    state_d = state_q;
    ivl_d   = ivl_q + 1'b1;
    qual_d  = qual_q;
    miss_d  = miss_q;
    mark    = 1'b0;

    unique case (state_q)
      StSearch, StHoldover: begin
        if (ivl_q >= IvlFree) begin
          mark  = 1'b1;
          ivl_d = '0;
        end
        if (pps_edge) begin
          if (!interval_good) begin
            qual_d = '0;
          end else if (qual_q == QualLast) begin
            state_d = StLocked;
            qual_d  = '0;
            miss_d  = '0;
            ivl_d   = '0;
            // A mark that just fired (or fires this cycle) already serves
            // as the locked mark; a second one would merge or crowd it.
            if (ivl_q >= IvlSettle) begin
              mark = 1'b1;
            end
          end else begin
            qual_d = qual_q + 1'b1;
          end
        end
      end

      StLocked: begin
        if (pps_edge && in_window) begin
          mark   = 1'b1;
          ivl_d  = '0;
          miss_d = '0;
        end else if (ivl_q >= IvlWinHi) begin
          mark = 1'b1;
          if (miss_q == MissLast) begin
            // Holdover free-runs a full second from this last mark.
            state_d = StHoldover;
            ivl_d   = '0;
            miss_d  = '0;
            qual_d  = '0;
          end else begin
            // Synthetic mark is TOL late; preload TOL to stay on nominal phase.
            ivl_d  = IvlTol;
            miss_d = miss_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = StSearch;
        ivl_d   = '0;
        qual_d  = '0;
        miss_d  = '0;
      end
    endcase
  end

  always_comb begin
    pulse_d = pulse_q;
    if (mark) begin
      pulse_d = PulseLoad;
    end else if (pulse_q != '0) begin
      pulse_d = pulse_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StSearch;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      pps_cnt_q    <= '0;
      pps_period_q <= '0;
      ivl_q        <= '0;
      qual_q       <= '0;
      miss_q       <= '0;
      pulse_q      <= '0;
    end else begin
      state_q      <= state_d;
      s1_q         <= pps_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      pps_cnt_q    <= pps_cnt_d;
      pps_period_q <= pps_period_d;
      ivl_q        <= ivl_d;
      qual_q       <= qual_d;
      miss_q       <= miss_d;
      pulse_q      <= pulse_d;
    end
  end

  assign sec        = (pulse_q != '0);
  assign locked     = (state_q == StLocked);
  assign holdover   = (state_q == StHoldover);
  assign pps_period = pps_period_q;

endmodule

// File: tb/tb_sec_mark_gen.sv
// Directed bench for sec_mark_gen with CLK_HZ=1000, TOL=10, QUAL=2,
// LOST_CNT=3, PULSE_W=4. Each table row names a checkpoint edge C (for
// rows with a pps pulse, C is the third clk edge sampling it high) and the
// expected sec/status/period at C plus the number of sec rises since the
// previous checkpoint. Reset cases are hand-written between row groups.
module tb_sec_mark_gen;

  localparam int unsigned ClkHz   = 1000;
  localparam int unsigned Tol     = 10;
  localparam int unsigned Qual    = 2;
  localparam int unsigned LostCnt = 3;
  localparam int unsigned PulseW  = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pps_in = 1'b0;
  logic        sec;
  logic        locked;
  logic        holdover;
  logic [31:0] pps_period;

  sec_mark_gen #(
    .CLK_HZ  (ClkHz),
    .TOL     (Tol),
    .QUAL    (Qual),
    .LOST_CNT(LostCnt),
    .PULSE_W (PulseW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pps_in    (pps_in),
    .sec       (sec),
    .locked    (locked),
    .holdover  (holdover),
    .pps_period(pps_period)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned at;      // checkpoint clk edge, counted from reset release
    bit          pps;     // pulse pps_in so that its E2 is 'at'
    bit          rise;    // sec rises exactly at 'at'
    int unsigned n;       // sec rises since previous checkpoint
    bit          lck;
    bit          hold;
    int unsigned period;
  } row_t;

  row_t        rows[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc;
  int unsigned last_rise = 0;
  int unsigned n_rises = 0;
  int unsigned prev_n = 0;
  int unsigned hi_cnt = 0;
  logic        sec_d = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string name, input longint unsigned got,
                       input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  // Records sec rises and checks every completed pulse is PULSE_W wide.
  always @(negedge clk) begin
    if (!rst) begin
      hi_cnt    = 0;
      sec_d     = 1'b0;
      last_rise = 0;
    end else begin
      if (sec && !sec_d) begin
        n_rises++;
        last_rise = cyc;
      end
      if (sec) begin
        hi_cnt++;
      end else if (hi_cnt != 0) begin
        check("sec_width", hi_cnt, PulseW);
        hi_cnt = 0;
      end
      sec_d = sec;
    end
  end

  initial begin
    #700000;
    $display("FAIL watchdog: run exceeded time limit, got timeout expected finish");
    $fatal(1);
  end

  // Returns just after the negedge that follows clk edge c.
  task automatic wait_cyc(input int unsigned c);
    do @(negedge clk); while (cyc < c);
    #1;
  endtask

  task automatic add(input int unsigned at, input bit pps, input bit rise,
                     input int unsigned n, input bit lck, input bit hold,
                     input int unsigned period);
    row_t r;
    r.at = at; r.pps = pps; r.rise = rise; r.n = n;
    r.lck = lck; r.hold = hold; r.period = period;
    rows.push_back(r);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      row_t r;
      r = rows[i];
      if (r.pps) begin
        wait_cyc(r.at - 3);
        pps_in = 1'b1;
      end
      wait_cyc(r.at);
      pps_in = 1'b0;
      check($sformatf("row%0d_rise", i), (last_rise == r.at), r.rise);
      check($sformatf("row%0d_marks", i), n_rises - prev_n, r.n);
      check($sformatf("row%0d_locked", i), locked, r.lck);
      check($sformatf("row%0d_holdover", i), holdover, r.hold);
      check($sformatf("row%0d_period", i), pps_period, r.period);
      prev_n = n_rises;
    end
  endtask

  // Asserts reset between edges, checks outputs drop at once, then releases.
  task automatic reset_cycle(input string tag);
    rst = 1'b0;
    #1;
    check({tag, "_sec"}, sec, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_holdover"}, holdover, 0);
    check({tag, "_period"}, pps_period, 0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    prev_n = n_rises;
  endtask

  initial begin
    // Epoch 1: free-run, lock, jitter, glitch, loss, holdover, re-lock.
    for (int k = 1; k <= 5; k++) add(k * 1000, 0, 1, 1, 0, 0, 0);
    add(5302,  1, 0, 0, 0, 0, 5302);
    add(6302,  1, 0, 1, 0, 0, 1000);
    add(7302,  1, 1, 2, 1, 0, 1000);
    add(8302,  1, 1, 1, 1, 0, 1000);
    add(9307,  1, 1, 1, 1, 0, 1005);
    add(10302, 1, 1, 1, 1, 0, 995);
    add(11302, 1, 1, 1, 1, 0, 1000);
    add(11802, 1, 0, 0, 1, 0, 500);
    add(12302, 1, 1, 1, 1, 0, 500);
    add(13312, 0, 1, 1, 1, 0, 500);
    add(14312, 0, 1, 1, 1, 0, 500);
    add(15312, 0, 1, 1, 0, 1, 500);
    add(16312, 0, 1, 1, 0, 1, 500);
    add(16702, 1, 0, 0, 0, 1, 4400);
    add(17702, 1, 0, 1, 0, 1, 1000);
    add(18702, 1, 1, 2, 1, 0, 1000);
    // Epoch 2: lock edge just after a free-run mark, then loss to holdover.
    add(1000,  0, 1, 1, 0, 0, 0);
    add(2003,  1, 0, 1, 0, 0, 2003);
    add(3003,  1, 0, 1, 0, 0, 1000);
    add(4003,  1, 0, 1, 1, 0, 1000);
    add(5003,  1, 1, 1, 1, 0, 1000);
    add(6013,  0, 1, 1, 1, 0, 1000);
    add(7013,  0, 1, 1, 1, 0, 1000);
    add(8013,  0, 1, 1, 0, 1, 1000);
    // Epoch 3: qualifying edge coincides with a free-run mark.
    add(1000,  1, 1, 1, 0, 0, 1000);
    add(2000,  1, 1, 1, 1, 0, 1000);
    add(3000,  1, 1, 1, 1, 0, 1000);

    #2;
    reset_cycle("rst_init");
    run_rows(0, 21);

    // Reset in the middle of the locked mark at 18702.
    wait_cyc(18704);
    check("sec_before_rst", sec, 1);
    reset_cycle("rst_in_pulse");
    run_rows(21, 29);

    wait_cyc(8500);
    check("holdover_before_rst", holdover, 1);
    reset_cycle("rst_in_holdover");
    run_rows(29, 32);

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
